karatsuba_mult_seq: RTL

- Parametrised sequential Karatsuba multiplier. Generalises the team's fixed 8-bit Karatsuba datapath to any even WIDTH.
- Adds a signed/unsigned mode, a start/busy/done handshake and a held product register.
- One shared (WIDTH/2+1)-bit half-width multiplier is time-multiplexed over three partial products.
- Sits between an operand source (CPU/regfile wrapper) and a result sink that consumes `done`.

---
 rtl/karatsuba_mult_seq.sv | 139 +++++++++++++
 1 files changed

// File: rtl/karatsuba_mult_seq.sv
// karatsuba_mult_seq
//   Sequential Karatsuba multiplier for any even WIDTH >= 4. A single shared
//   (WIDTH/2+1)-bit multiplier computes the three partial products in turn.
//   The operands are converted to magnitudes at start. The sign is applied to
//   the result at the end.
//
// Ports
//   CLK          clock, rising edge
//   RESET        asynchronous, active-high reset
//   start        request, sampled only in IDLE
//   signed_mode  1 = two's-complement operands, sampled with start
//   w, y         operands, sampled with start
//   busy         high from SUM through SIGN
//   done         one-cycle pulse while in DONE; product is valid
//   product      2*WIDTH-bit result, held until the next done
module karatsuba_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     w,
    input  logic [WIDTH-1:0]     y,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int H = WIDTH / 2;
    localparam logic [WIDTH-1:0]   ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_P = {{(2*WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE, SUM, MUL_A, MUL_B, MUL_C, COMBINE, SIGN, DONE
    } state_t;

    state_t state, state_nx;

    logic                 neg;
    logic [WIDTH-1:0]     mw, my;
    logic [H:0]           d, e;
    logic [WIDTH-1:0]     a, b;
    logic [WIDTH+1:0]     c;
    logic [2*WIDTH-1:0]   p;

    // Shared half-width multiplier and its operand select
    logic [H:0]           mul_x, mul_y;
    logic [WIDTH+1:0]     mul_p;
    logic [WIDTH+1:0]     m;
    logic [2*WIDTH-1:0]   p_comb;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = SUM;
            SUM:     state_nx = MUL_A;
            MUL_A:   state_nx = MUL_B;
            MUL_B:   state_nx = MUL_C;
            MUL_C:   state_nx = COMBINE;
            COMBINE: state_nx = SIGN;
            SIGN:    state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE) && (state != DONE);
    assign done = (state == DONE);

    always_comb begin
        mul_x = '0;
        mul_y = '0;
        case (state)
            MUL_A: begin
                mul_x = {1'b0, mw[H-1:0]};
                mul_y = {1'b0, my[H-1:0]};
            end
            MUL_B: begin
                mul_x = {1'b0, mw[WIDTH-1:H]};
                mul_y = {1'b0, my[WIDTH-1:H]};
            end
            MUL_C: begin
                mul_x = d;
                mul_y = e;
            end
            default: ;
        endcase
    end

    assign mul_p = {{(H+1){1'b0}}, mul_x} * {{(H+1){1'b0}}, mul_y};

    // The middle term C - A - B = hi*lo' + lo*hi' cannot go negative.
    // It is carried at C's width and zero-extended into the 2*WIDTH sum.
    assign m      = c - {2'b00, a} - {2'b00, b};
    assign p_comb = {b, {WIDTH{1'b0}}}
                  + ({{(WIDTH-2){1'b0}}, m} << H)
                  + {{WIDTH{1'b0}}, a};

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            neg     <= 1'b0;
            mw      <= '0;
            my      <= '0;
            d       <= '0;
            e       <= '0;
            a       <= '0;
            b       <= '0;
            c       <= '0;
            p       <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    neg <= signed_mode & (w[WIDTH-1] ^ y[WIDTH-1]);
                    // Negating the most negative value wraps to 2^(WIDTH-1).
                    // That is the correct magnitude when read as unsigned.
                    mw  <= (signed_mode && w[WIDTH-1]) ? (~w + ONE_W) : w;
                    my  <= (signed_mode && y[WIDTH-1]) ? (~y + ONE_W) : y;
                end
                SUM: begin
                    d <= {1'b0, mw[WIDTH-1:H]} + {1'b0, mw[H-1:0]};
                    e <= {1'b0, my[WIDTH-1:H]} + {1'b0, my[H-1:0]};
                end
                MUL_A:   a <= mul_p[WIDTH-1:0];
                MUL_B:   b <= mul_p[WIDTH-1:0];
                MUL_C:   c <= mul_p;
                COMBINE: p <= p_comb;
                // A zero magnitude negates to zero, so no negative zero results.
                SIGN:    product <= neg ? (~p + ONE_P) : p;
                default: ;
            endcase
        end
    end
endmodule
